// File: rtl/parser_pkg.sv
// Shared definitions for the parser front end: tag bit layout, default widths
// and the framer state encoding.
package parser_pkg;

    // Tag bit positions consumed downstream by Shift_Head.
    localparam int TAG_VALID_BIT = 0;
    localparam int TAG_SHIFT_BIT = 1;
    localparam int TAG_FIRST_BIT = 2;

    localparam int DEF_DATA_WIDTH       = 128;
    localparam int DEF_HEAD_WIDTH       = 512;
    localparam int DEF_META_WIDTH       = 256;
    localparam int DEF_HEAD_SHIFT_WIDTH = 4;
    localparam int DEF_META_SHIFT_WIDTH = 4;
    localparam int DEF_TAG_WIDTH        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT1,
        ST_COLLECT2,
        ST_PAD2,
        ST_PAYLOAD
    } framer_state_e;

    // Tag for an emitted word; the valid bit is always set.
    function automatic logic [2:0] tag_bits(input logic first, input logic shift);
        logic [2:0] t;
        t                = '0;
        t[TAG_VALID_BIT] = 1'b1;
        t[TAG_SHIFT_BIT] = shift;
        t[TAG_FIRST_BIT] = first;
        return t;
    endfunction

endpackage

// File: rtl/pld_skid_buf.sv
// One-entry valid/ready register for the payload stream; holds data stable
// while the consumer stalls.
module pld_skid_buf #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_eop,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_eop,
    input  logic                  i_ready
);

    assign o_ready = !o_valid || i_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_eop   <= 1'b0;
        end else if (i_valid && o_ready) begin
            o_data  <= i_data;
            o_eop   <= i_eop;
            o_valid <= 1'b1;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/head_framer.sv
// Frames each packet into two tagged head/meta words for Shift_Head and
// forwards the remaining beats on a backpressured payload stream.
module head_framer
    import parser_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int HEAD_WIDTH       = DEF_HEAD_WIDTH,
    parameter int META_WIDTH       = DEF_META_WIDTH,
    parameter int HEAD_SHIFT_WIDTH = DEF_HEAD_SHIFT_WIDTH,
    parameter int META_SHIFT_WIDTH = DEF_META_SHIFT_WIDTH,
    parameter int TAG_WIDTH        = DEF_TAG_WIDTH
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [DATA_WIDTH-1:0]           i_data,
    input  logic                            i_valid,
    input  logic                            i_sop,
    input  logic                            i_eop,
    output logic                            o_ready,
    input  logic [HEAD_SHIFT_WIDTH-1:0]     i_cfg_head_shift,
    input  logic [META_SHIFT_WIDTH-1:0]     i_cfg_meta_shift,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    output logic [HEAD_SHIFT_WIDTH-1:0]     o_headShift,
    output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
    output logic [META_SHIFT_WIDTH-1:0]     o_metaShift,
    output logic [DATA_WIDTH-1:0]           o_pld_data,
    output logic                            o_pld_valid,
    output logic                            o_pld_eop,
    input  logic                            i_pld_ready
);

    localparam int BEATS = HEAD_WIDTH / DATA_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    framer_state_e               state_q, state_d;
    logic                        ready_en_q;
    logic [HEAD_WIDTH-1:0]       acc_q, fill_word;
    logic [CNT_W-1:0]            cnt_q;
    logic [HEAD_SHIFT_WIDTH-1:0] hshift_q, cur_hshift;
    logic [META_SHIFT_WIDTH-1:0] mshift_q, cur_mshift;
    logic [7:0]                  seq_q;
    logic                        collecting, beat_fire, word_done, is_first;
    logic                        pld_in_valid, pld_in_ready;

    assign beat_fire    = i_valid & o_ready;
    assign is_first     = (state_q != ST_COLLECT2);
    assign word_done    = beat_fire & collecting & (i_eop | (cnt_q == LAST_BEAT));
    assign pld_in_valid = beat_fire & (state_q == ST_PAYLOAD);
    // A word can complete on the sop beat itself, before the amounts are latched.
    assign cur_hshift   = (state_q == ST_IDLE) ? i_cfg_head_shift : hshift_q;
    assign cur_mshift   = (state_q == ST_IDLE) ? i_cfg_meta_shift : mshift_q;

    always_comb begin
        fill_word = acc_q;
        for (int s = 0; s < BEATS; s++) begin
            if (cnt_q == CNT_W'(s)) fill_word[s*DATA_WIDTH +: DATA_WIDTH] = i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_COLLECT1, ST_COLLECT2: begin
                if (word_done) begin
                    if (is_first) state_d = i_eop ? ST_PAD2 : ST_COLLECT2;
                    else          state_d = i_eop ? ST_IDLE : ST_PAYLOAD;
                end else if (beat_fire && collecting && state_q == ST_IDLE) begin
                    state_d = ST_COLLECT1;
                end
            end
            ST_PAD2: state_d = ST_IDLE;
            // The eop beat sitting in the skid register marks the packet end.
            ST_PAYLOAD: if (o_pld_valid && o_pld_eop && i_pld_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready    = 1'b0;
        collecting = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                o_ready    = ready_en_q;
                collecting = i_sop;
            end
            ST_COLLECT1, ST_COLLECT2: begin
                o_ready    = ready_en_q;
                collecting = 1'b1;
            end
            ST_PAYLOAD:
                o_ready = ready_en_q & i_pld_ready & pld_in_ready & ~(o_pld_valid & o_pld_eop);
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            hshift_q    <= '0;
            mshift_q    <= '0;
            seq_q       <= '0;
            o_head      <= '0;
            o_meta      <= '0;
            o_headShift <= '0;
            o_metaShift <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            o_head      <= '0;
            o_meta      <= '0;
            o_headShift <= '0;
            o_metaShift <= '0;
            if (beat_fire && collecting) begin
                if (state_q == ST_IDLE) begin
                    hshift_q <= i_cfg_head_shift;
                    mshift_q <= i_cfg_meta_shift;
                end
                if (word_done) begin
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    o_head <= {TAG_WIDTH'(tag_bits(is_first, is_first && cur_hshift != '0)),
                               fill_word};
                    o_meta <= {TAG_WIDTH'(tag_bits(is_first, is_first && cur_mshift != '0)),
                               META_WIDTH'(seq_q)};
                    if (is_first) begin
                        o_headShift <= cur_hshift;
                        o_metaShift <= cur_mshift;
                    end else begin
                        seq_q <= seq_q + 8'd1;
                    end
                end else begin
                    acc_q <= fill_word;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (state_q == ST_PAD2) begin
                o_head <= {TAG_WIDTH'(tag_bits(1'b0, 1'b0)), HEAD_WIDTH'(0)};
                o_meta <= {TAG_WIDTH'(tag_bits(1'b0, 1'b0)), META_WIDTH'(seq_q)};
                seq_q  <= seq_q + 8'd1;
            end
        end
    end

    pld_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pld_skid_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_valid (pld_in_valid),
        .i_eop   (i_eop),
        .o_ready (pld_in_ready),
        .o_data  (o_pld_data),
        .o_valid (o_pld_valid),
        .o_eop   (o_pld_eop),
        .i_ready (i_pld_ready)
    );

endmodule

// File: tb/tb_head_framer.sv
// Self-checking bench for head_framer: a per-cycle vector table for short
// packets plus directed sequences for payload, gaps, reset and wrap-around.
module tb_head_framer;

    localparam int DW = 128;
    localparam int HW = 512;
    localparam int MW = 256;
    localparam int TW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     i_data;
    logic              i_valid, i_sop, i_eop, o_ready;
    logic [3:0]        i_cfg_head_shift, i_cfg_meta_shift;
    logic [HW+TW-1:0]  o_head;
    logic [3:0]        o_headShift, o_metaShift;
    logic [MW+TW-1:0]  o_meta;
    logic [DW-1:0]     o_pld_data;
    logic              o_pld_valid, o_pld_eop, i_pld_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    head_framer dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_data           (i_data),
        .i_valid          (i_valid),
        .i_sop            (i_sop),
        .i_eop            (i_eop),
        .o_ready          (o_ready),
        .i_cfg_head_shift (i_cfg_head_shift),
        .i_cfg_meta_shift (i_cfg_meta_shift),
        .o_head           (o_head),
        .o_headShift      (o_headShift),
        .o_meta           (o_meta),
        .o_metaShift      (o_metaShift),
        .o_pld_data       (o_pld_data),
        .o_pld_valid      (o_pld_valid),
        .o_pld_eop        (o_pld_eop),
        .i_pld_ready      (i_pld_ready)
    );

    typedef struct {
        logic [HW+TW-1:0] head;
        logic [3:0]       hs;
        logic [MW+TW-1:0] meta;
        logic [3:0]       ms;
    } cap_t;

    typedef struct {
        logic             valid, sop, eop;
        logic [DW-1:0]    data;
        logic [3:0]       hs, ms;
        logic             exp_ready;
        logic [HW+TW-1:0] exp_head;
        logic [3:0]       exp_hshift;
        logic [MW+TW-1:0] exp_meta;
        logic [3:0]       exp_mshift;
    } row_t;

    cap_t          hq[$];
    logic [DW:0]   pq[$];
    row_t          tbl[15];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_head[HW] === 1'b1)
            hq.push_back('{head: o_head, hs: o_headShift, meta: o_meta, ms: o_metaShift});
        if (rst_n === 1'b1 && o_pld_valid === 1'b1 && i_pld_ready === 1'b1)
            pq.push_back({o_pld_eop, o_pld_data});
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] beat_data(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {4{16'hBEA7, b, ~b}};
    endfunction

    function automatic logic [TW-1:0] tag(input logic first, input logic shift);
        return {1'b0, first, shift, 1'b1};
    endfunction

    function automatic logic [HW+TW-1:0] hword(input logic [TW-1:0] t, input logic [HW-1:0] d);
        return {t, d};
    endfunction

    function automatic logic [MW+TW-1:0] mword(input logic [TW-1:0] t, input logic [7:0] s);
        return {t, {(MW-8){1'b0}}, s};
    endfunction

    // Expected data of head word w (0 or 1) for an n-beat packet.
    function automatic logic [HW-1:0] pkt_word(input int w, input int n, input int off);
        logic [HW-1:0] r;
        r = '0;
        for (int s = 0; s < 4; s++) begin
            if (w * 4 + s < n) r[s*DW +: DW] = beat_data(off + w * 4 + s);
        end
        return r;
    endfunction

    function automatic row_t mk(input logic v, sop, eop, input logic [DW-1:0] d,
                                input logic [3:0] hs, ms, input logic er,
                                input logic [HW+TW-1:0] eh, input logic [3:0] ehs,
                                input logic [MW+TW-1:0] em, input logic [3:0] ems);
        row_t r;
        r.valid = v; r.sop = sop; r.eop = eop; r.data = d; r.hs = hs; r.ms = ms;
        r.exp_ready = er; r.exp_head = eh; r.exp_hshift = ehs;
        r.exp_meta = em; r.exp_mshift = ems;
        return r;
    endfunction

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic sop, eop,
                             input logic [3:0] hs, ms);
        bit ok;
        int waited;
        ok = 0;
        waited = 0;
        i_valid = 1'b1; i_data = d; i_sop = sop; i_eop = eop;
        i_cfg_head_shift = hs; i_cfg_meta_shift = ms;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (o_ready === 1'b1) ok = 1;
            @(posedge clk);
            #1;
            waited++;
        end
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept: beat %0h not accepted within 50 cycles", d);
        end
    endtask

    task automatic send_pkt(input int n, input int off, input logic [3:0] hs, ms,
                            input int gap_after);
        for (int k = 0; k < n; k++) begin
            send_beat(beat_data(off + k), k == 0, k == n - 1,
                      (k == 0) ? hs : 4'hF, (k == 0) ? ms : 4'hF);
            if (k == gap_after) repeat (3) begin @(posedge clk); #1; end
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_words(input string name, input int n, input int off,
                               input logic [3:0] hs, ms, input logic [7:0] seq);
        check({name, " word count"}, hq.size(), 2);
        if (hq.size() == 2) begin
            check({name, " w1 head"}, hq[0].head, hword(tag(1, hs != 0), pkt_word(0, n, off)));
            check({name, " w1 hshift"}, hq[0].hs, hs);
            check({name, " w1 meta"}, hq[0].meta, mword(tag(1, ms != 0), seq));
            check({name, " w1 mshift"}, hq[0].ms, ms);
            check({name, " w2 head"}, hq[1].head, hword(tag(0, 0), pkt_word(1, n, off)));
            check({name, " w2 hshift"}, hq[1].hs, 4'h0);
            check({name, " w2 meta"}, hq[1].meta, mword(tag(0, 0), seq));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("reset ready", o_ready, 1'b0);
        check("reset head", o_head, '0);
        check("reset meta", o_meta, '0);
        check("reset pld_valid", o_pld_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] a5, x5a;
        logic [HW+TW-1:0] zh;
        logic [MW+TW-1:0] zm;

        a5  = {16{8'hA5}};
        x5a = {16{8'h5A}};
        zh  = '0;
        zm  = '0;

        tbl[0]  = mk(0, 0, 0, '0, 0, 0, 1, zh, 0, zm, 0);
        tbl[1]  = mk(1, 1, 1, a5, 3, 2, 1, hword(tag(1, 1), {{(HW-DW){1'b0}}, a5}), 3,
                     mword(tag(1, 1), 8'd0), 2);
        tbl[2]  = mk(0, 0, 0, '0, 0, 0, 0, hword(tag(0, 0), '0), 0, mword(tag(0, 0), 8'd0), 0);
        tbl[3]  = mk(0, 0, 0, '0, 0, 0, 1, zh, 0, zm, 0);
        tbl[4]  = mk(1, 1, 1, x5a, 0, 6, 1, hword(tag(1, 0), {{(HW-DW){1'b0}}, x5a}), 0,
                     mword(tag(1, 1), 8'd1), 6);
        tbl[5]  = mk(0, 0, 0, '0, 0, 0, 0, hword(tag(0, 0), '0), 0, mword(tag(0, 0), 8'd1), 0);
        for (int k = 0; k < 8; k++) begin
            tbl[6+k] = mk(1, k == 0, k == 7, beat_data(k),
                          (k == 0) ? 4'h0 : 4'hF, (k == 0) ? 4'h0 : 4'hF, 1,
                          (k == 3) ? hword(tag(1, 0), pkt_word(0, 8, 0)) :
                          (k == 7) ? hword(tag(0, 0), pkt_word(1, 8, 0)) : zh, 0,
                          (k == 3) ? mword(tag(1, 0), 8'd2) :
                          (k == 7) ? mword(tag(0, 0), 8'd2) : zm, 0);
        end
        tbl[14] = mk(0, 0, 0, '0, 0, 0, 1, zh, 0, zm, 0);

        rst_n = 1'b0;
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_data = '0;
        i_cfg_head_shift = '0; i_cfg_meta_shift = '0; i_pld_ready = 1'b1;

        #12;
        check("reset ready", o_ready, 1'b0);
        check("reset head", o_head, '0);
        check("reset meta", o_meta, '0);
        check("reset shifts", {o_headShift, o_metaShift}, 8'h00);
        check("reset pld_valid", o_pld_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready after reset", o_ready, 1'b1);

        // Per-cycle vectors: 1-beat packets (PAD2 path) and an 8-beat packet.
        for (int i = 0; i < 15; i++) begin
            i_valid = tbl[i].valid; i_sop = tbl[i].sop; i_eop = tbl[i].eop;
            i_data = tbl[i].data;
            i_cfg_head_shift = tbl[i].hs; i_cfg_meta_shift = tbl[i].ms;
            @(negedge clk);
            check($sformatf("row%0d ready", i), o_ready, tbl[i].exp_ready);
            @(posedge clk);
            #1;
            check($sformatf("row%0d head", i), o_head, tbl[i].exp_head);
            check($sformatf("row%0d hshift", i), o_headShift, tbl[i].exp_hshift);
            check($sformatf("row%0d meta", i), o_meta, tbl[i].exp_meta);
            check($sformatf("row%0d mshift", i), o_metaShift, tbl[i].exp_mshift);
            check($sformatf("row%0d pld_valid", i), o_pld_valid, 1'b0);
        end
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;

        // 11-beat packet with payload consumer stalled on beat 9.
        hq.delete();
        pq.delete();
        for (int k = 0; k < 9; k++)
            send_beat(beat_data(16 + k), k == 0, 1'b0, (k == 0) ? 4'h1 : 4'hF, 4'h0);
        i_pld_ready = 1'b0;
        i_valid = 1'b1; i_data = beat_data(16 + 9);
        repeat (2) begin
            @(negedge clk);
            check("stall ready", o_ready, 1'b0);
            check("stall pld_valid", o_pld_valid, 1'b1);
            check("stall pld_data", o_pld_data, beat_data(16 + 8));
            @(posedge clk);
            #1;
        end
        i_pld_ready = 1'b1;
        send_beat(beat_data(16 + 9), 1'b0, 1'b0, 4'hF, 4'hF);
        send_beat(beat_data(16 + 10), 1'b0, 1'b1, 4'hF, 4'hF);
        repeat (4) begin @(posedge clk); #1; end
        check("pld count", pq.size(), 3);
        if (pq.size() == 3) begin
            check("pld beat8", pq[0], {1'b0, beat_data(24)});
            check("pld beat9", pq[1], {1'b0, beat_data(25)});
            check("pld beat10", pq[2], {1'b1, beat_data(26)});
        end
        check_words("pkt11", 11, 16, 4'h1, 4'h0, 8'd3);
        check("idle after payload", o_ready, 1'b1);

        // Same 5-beat packet without and with an input gap after beat 1.
        hq.delete();
        send_pkt(5, 32, 4'h2, 4'h1, -1);
        check_words("nogap", 5, 32, 4'h2, 4'h1, 8'd4);
        hq.delete();
        send_pkt(5, 32, 4'h2, 4'h1, 1);
        check_words("gap", 5, 32, 4'h2, 4'h1, 8'd5);

        // Reset mid-packet discards the partial word and the sequence count.
        hq.delete();
        send_beat(beat_data(48), 1'b1, 1'b0, 4'h3, 4'h3);
        send_beat(beat_data(49), 1'b0, 1'b0, 4'hF, 4'hF);
        do_reset();
        repeat (2) begin @(posedge clk); #1; end
        check("abort no word", hq.size(), 0);
        send_pkt(5, 64, 4'h0, 4'h0, -1);
        check_words("after reset", 5, 64, 4'h0, 4'h0, 8'd0);

        // 257 back-to-back 1-beat packets: sequence wraps 255 -> 0.
        do_reset();
        hq.delete();
        for (int i = 0; i < 257; i++) send_beat(beat_data(i), 1'b1, 1'b1, 4'h0, 4'h0);
        repeat (3) begin @(posedge clk); #1; end
        check("wrap word count", hq.size(), 514);
        for (int i = 0; i < 257; i++) begin
            if (2 * i + 1 < hq.size()) begin
                check($sformatf("wrap pkt%0d w1 meta", i), hq[2*i].meta, mword(tag(1, 0), 8'(i)));
                check($sformatf("wrap pkt%0d w2 meta", i), hq[2*i+1].meta, mword(tag(0, 0), 8'(i)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
